// File: rtl/instruction_sequencer.sv
// Fetch/sequence unit: drives the instruction ROM address, holds pc and the
// instruction register, resolves JMP/ATC control flow and keeps sticky
// attention latches that ATC instructions poll and consume.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_FETCH | address=pc, ROM word is captured into instr at the edge
// S_EXEC  | instr is executed; stall holds here; control flow resolved on exit
module instruction_sequencer #(
    parameter logic [7:0] RESET_PC  = 8'd0,
    parameter int         ATC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [7:0]           address,
    input  logic [31:0]          instruction,
    output logic [31:0]          instr,
    output logic                 exec,
    input  logic                 stall,
    input  logic                 cond_true,
    input  logic [ATC_WIDTH-1:0] attn_in,
    output logic [ATC_WIDTH-1:0] attn_pending,
    output logic [7:0]           pc
);

    // Opcode map for instr[31:29]; STD_ACC=000, MOR_ACC=001, MOV=010 are plain
    // datapath classes and need no special handling here.
    localparam logic [2:0] OP_JMP = 3'b011;
    localparam logic [2:0] OP_ATC = 3'b100;

    typedef enum logic {S_FETCH, S_EXEC} state_t;

    state_t               state;
    logic                 is_jmp;
    logic                 is_atc;
    logic [2:0]           atc_bit;
    logic [7:0]           target;
    logic [7:0]           attn_view;
    logic                 advance;
    logic                 atc_taken;
    logic [7:0]           pc_next;
    logic [ATC_WIDTH-1:0] clr_mask;

    assign is_jmp  = (instr[31:29] == OP_JMP);
    assign is_atc  = (instr[31:29] == OP_ATC);
    assign atc_bit = instr[28:26];
    assign target  = instr[7:0];

    assign address = pc;
    assign exec    = (state == S_EXEC) && !is_jmp && !is_atc;
    assign advance = (state == S_EXEC) && !stall;

    // 8-bit view of the latches; positions beyond ATC_WIDTH read as zero so an
    // ATC on them can never be taken.
    for (genvar g = 0; g < 8; g++) begin : g_view
        if (g < ATC_WIDTH) begin : g_real
            assign attn_view[g] = attn_pending[g];
        end else begin : g_pad
            assign attn_view[g] = 1'b0;
        end
    end

    assign atc_taken = advance && is_atc && attn_view[atc_bit];

    // One-hot clear for the latch consumed by a taken ATC.
    for (genvar g = 0; g < ATC_WIDTH; g++) begin : g_clr
        if (g < 8) begin : g_idx
            assign clr_mask[g] = atc_taken && (atc_bit == 3'(g));
        end else begin : g_none
            assign clr_mask[g] = 1'b0;
        end
    end

    // Next pc on leaving EXEC: taken JMP/ATC go to target, otherwise pc+1 (mod 256).
    always_comb begin
        pc_next = pc + 8'd1;
        if (is_jmp && cond_true) begin
            pc_next = target;
        end else if (atc_taken) begin
            pc_next = target;
        end
    end

    // Fetch/exec sequencing of state, pc and the instruction register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            instr <= 32'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    instr <= instruction;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (!stall) begin
                        pc    <= pc_next;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Sticky attention latches; a new event on the same edge as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            attn_pending <= '0;
        end else begin
            attn_pending <= (attn_pending & ~clr_mask) | attn_in;
        end
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Fetch/sequence unit that reads the CPU's 256-entry combinational instruction ROM and drives its 8-bit address.
- Holds the program counter and the instruction register, and resolves control flow for JMP and ATC instructions.
- Keeps sticky attention latches for external events (PUSH, POP, ADD, MULT, SUB, DIV, OFLW, ...).
- Hands non-control instructions to the datapath through an exec strobe with a stall handshake.

Parameters:
- RESET_PC, 8'd0, PC value loaded on reset.
- ATC_WIDTH, 8, number of attention latches; the ATC bit field (3 bits) indexes them.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  output  8  ROM address; equals pc.
- instruction  input  32  ROM data for address (combinational, valid same cycle).
- instr  output  32  registered current instruction, to datapath/decoder.
- exec  output  1  high in EXEC when the current instr is not JMP/ATC.
- stall  input  1  datapath busy; holds EXEC (multi-cycle ops).
- cond_true  input  1  datapath compare result for the current JMP condition (UNC, EQ, SLE, ...); sampled only for JMP.
- attn_in  input  ATC_WIDTH  event pulses; one bit per ATC source.
- attn_pending  output  ATC_WIDTH  current sticky latch contents.
- pc  output  8  program counter (debug).

Behaviour:
- Instruction fields:
  - [31:29] class/opcode (`JMP, `ATC, `MOV, `STD_ACC, `MOR_ACC per cpu_definitions.vh).
  - [28:26] op / condition / atc_bit.
  - [25] arg1 type, [24:17] arg1.
  - [16] arg2 type, [15:8] arg2.
  - [7:0] target address.
- Reset (async, any state, including mid-EXEC or mid-stall): pc=RESET_PC, instr=32'd0, state=FETCH, attn latches=0, exec=0. No partial update survives.
- FETCH (1 cycle):
  - address=pc.
  - At the clock edge: instr<=instruction, state<=EXEC.
  - exec=0 in FETCH.
- EXEC:
  - exec = (instr[31:29] != `JMP && instr[31:29] != `ATC).
  - If stall=1 at the edge: remain in EXEC; pc, instr and exec are unchanged.
  - If stall=0 at the edge: next pc is set per the control-flow rules below, and state<=FETCH.
- Control flow at the EXEC edge:
  - JMP: pc<=instr[7:0] if cond_true, else pc+1.
  - ATC: b=instr[28:26]. If the latch[b] value visible during EXEC is set, pc<=instr[7:0] and latch[b] is cleared. Otherwise pc<=pc+1.
  - All others, including NOP 32'd0: pc<=pc+1.
- Throughput: 2 cycles per instruction with no stall; 2+N cycles when stall is high for N EXEC cycles.
- PC arithmetic is 8-bit modulo: 255+1 wraps to 0. A jump to any address 0..255 is legal.
- Attention latches:
  - latch[i] is set on any clock where attn_in[i]=1. Inputs are level-sampled, so a multi-cycle pulse is the same as a single event.
  - Clearing happens only through a taken ATC on that bit.
  - Same-cycle set and clear of the same bit: set wins, so the new event is retained.
  - Other bits are never affected by an ATC.
  - Bits >= ATC_WIDTH (when ATC_WIDTH<8) read as 0, so an ATC on them is never taken.
- Wait loop: the ATC chain at 0..6 polls one latch per instruction. Latches make events arriving between polls persist until consumed.
- Outputs instr, pc and attn_pending are registered. exec and address are combinational from registers only, with no combinational path from inputs.

Test Plan:
- Reset release with ROM NOPs:
  - address sequence is 0,0,1,1,2,2,... (2 cycles each), exec is high every second cycle.
  - Reset asserted again mid-EXEC forces address=0 and instr=0 immediately.
- Unconditional jump: JMP UNC 0 placed at address 6 -> after the EXEC edge the next address is 0. PC wrap: execute NOP at 255 -> next address 0.
- Conditional jump at address 13 (EQ target 19):
  - cond_true=1 -> next address 19.
  - cond_true=0 -> next address 14.
  - exec=0 in both cases.
- ATC polling:
  - Pulse attn_in[1] (POP) for 1 cycle while the sequencer sits at address 0 -> ATC PUSH falls through to 1.
  - ATC POP at 1 jumps to 25; attn_pending[1] clears on that edge; attn_pending[0] is untouched.
- ATC set/clear collision: attn_in[1]=1 on the same edge as a taken ATC POP -> jump taken and attn_pending[1] stays 1.
- Stall: hold stall=1 for 3 cycles during a MOR_ACC at address 95 -> exec stays 1, address stays 95 for 4 EXEC cycles, then next fetch is address 96.
